// File: rtl/bus_responder_8227.sv
// Memory and peripheral responder for the top8227 CPU bus. It provides RAM, vectors,
// a down-counter IRQ timer, an NMI pulse generator and a host preload port.
module bus_responder_8227 #(
    parameter int          RAM_PAGES    = 2,
    parameter logic [15:0] RESET_VECTOR = 16'h0200,
    parameter logic [15:0] NMI_VECTOR   = 16'h0300,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0400,
    parameter int          NMI_PULSE    = 2,
    parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  addressBusHigh,
    input  logic [7:0]  addressBusLow,
    input  logic        readNotWrite,
    input  logic [7:0]  cpuWriteData,
    output logic [7:0]  cpuReadData,
    output logic        interruptRequest,
    output logic        nonMaskableInterrupt,
    input  logic        hostLoadEnable,
    input  logic [15:0] hostLoadAddr,
    input  logic [7:0]  hostLoadData,
    output logic        busError
);

    localparam int          RAM_BYTES = RAM_PAGES * 256;
    localparam int          RAM_AW    = $clog2(RAM_BYTES);
    localparam logic [16:0] RAM_TOP   = 17'(RAM_BYTES);
    localparam logic [3:0]  NMI_LOAD  = 4'(NMI_PULSE);

    logic [15:0] addr;
    logic        cpu_wr;
    logic        sel_ram, sel_ctrl, sel_rl_lo, sel_rl_hi, sel_stat, sel_nmi, sel_vec, mapped;
    logic        host_ram, host_vec;
    logic [2:0]  vec_idx, host_vec_idx;
    logic        expire;
    logic [7:0]  rd_data;

    logic [7:0]  ram_q [RAM_BYTES];
    logic [7:0]  vec_q [6];

    logic [7:0]  rdata_q, rdata_d;
    logic        berr_q, berr_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic        ctrl_auto_q, ctrl_auto_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [3:0]  nmi_cnt_q, nmi_cnt_d;

    assign addr   = {addressBusHigh, addressBusLow};
    assign cpu_wr = ~readNotWrite;

    // 0xFFFA has low bits 3'b010, so subtracting 2 maps the six vector bytes to 0..5.
    assign vec_idx      = addr[2:0] - 3'd2;
    assign host_vec_idx = hostLoadAddr[2:0] - 3'd2;

    always_comb begin
        sel_ram   = ({1'b0, addr} < RAM_TOP);
        sel_ctrl  = (addr == 16'hD000);
        sel_rl_lo = (addr == 16'hD001);
        sel_rl_hi = (addr == 16'hD002);
        sel_stat  = (addr == 16'hD003);
        sel_nmi   = (addr == 16'hD004);
        sel_vec   = (addr >= 16'hFFFA);
        mapped    = sel_ram | sel_ctrl | sel_rl_lo | sel_rl_hi | sel_stat | sel_nmi | sel_vec;
        host_ram  = hostLoadEnable && ({1'b0, hostLoadAddr} < RAM_TOP);
        host_vec  = hostLoadEnable && (hostLoadAddr >= 16'hFFFA);
    end

    always_comb begin
        rd_data = OPEN_BUS;
        if (sel_ram)        rd_data = ram_q[addr[RAM_AW-1:0]];
        else if (sel_ctrl)  rd_data = {6'd0, ctrl_auto_q, ctrl_en_q};
        else if (sel_rl_lo) rd_data = reload_q[7:0];
        else if (sel_rl_hi) rd_data = reload_q[15:8];
        else if (sel_stat)  rd_data = {7'd0, pend_q};
        else if (sel_nmi)   rd_data = 8'h00;
        else if (sel_vec)   rd_data = vec_q[vec_idx];
    end

    // A count of 0 while enabled counts as expiry too, so RELOAD = 0 fires every cycle.
    assign expire = ctrl_en_q && (cnt_q <= 16'd1);

    always_comb begin
        rdata_d     = cpu_wr ? cpuWriteData : rd_data;
        berr_d      = ~mapped;
        ctrl_en_d   = ctrl_en_q;
        ctrl_auto_d = ctrl_auto_q;
        reload_d    = reload_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        nmi_cnt_d   = nmi_cnt_q;

        if (ctrl_en_q) begin
            if (expire) begin
                if (ctrl_auto_q) begin
                    cnt_d = reload_q;
                end else begin
                    cnt_d     = 16'd0;
                    ctrl_en_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end

        if (cpu_wr && sel_stat && cpuWriteData[0]) pend_d = 1'b0;
        if (expire) pend_d = 1'b1;

        if (cpu_wr && sel_ctrl) begin
            ctrl_en_d   = cpuWriteData[0];
            ctrl_auto_d = cpuWriteData[1];
            if (cpuWriteData[0]) cnt_d = reload_q;
        end
        if (cpu_wr && sel_rl_lo) reload_d[7:0]  = cpuWriteData;
        if (cpu_wr && sel_rl_hi) reload_d[15:8] = cpuWriteData;

        if (nmi_cnt_q != 4'd0) nmi_cnt_d = nmi_cnt_q - 4'd1;
        if (cpu_wr && sel_nmi) nmi_cnt_d = NMI_LOAD;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata_q     <= 8'h00;
            berr_q      <= 1'b0;
            ctrl_en_q   <= 1'b0;
            ctrl_auto_q <= 1'b0;
            reload_q    <= 16'd0;
            cnt_q       <= 16'd0;
            pend_q      <= 1'b0;
            nmi_cnt_q   <= 4'd0;
            vec_q[0]    <= NMI_VECTOR[7:0];
            vec_q[1]    <= NMI_VECTOR[15:8];
            vec_q[2]    <= RESET_VECTOR[7:0];
            vec_q[3]    <= RESET_VECTOR[15:8];
            vec_q[4]    <= IRQ_VECTOR[7:0];
            vec_q[5]    <= IRQ_VECTOR[15:8];
        end else begin
            rdata_q     <= rdata_d;
            berr_q      <= berr_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_auto_q <= ctrl_auto_d;
            reload_q    <= reload_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            nmi_cnt_q   <= nmi_cnt_d;
            if (host_vec) vec_q[host_vec_idx] <= hostLoadData;
        end
    end

    // RAM is deliberately not reset; the host write is ordered last so it wins a collision.
    always_ff @(posedge clk) begin
        if (cpu_wr && sel_ram && !(host_ram && (hostLoadAddr == addr)))
            ram_q[addr[RAM_AW-1:0]] <= cpuWriteData;
        if (host_ram)
            ram_q[hostLoadAddr[RAM_AW-1:0]] <= hostLoadData;
    end

    assign cpuReadData          = rdata_q;
    assign interruptRequest     = pend_q;
    assign nonMaskableInterrupt = (nmi_cnt_q != 4'd0);
    assign busError             = berr_q;

endmodule

// File: tb/tb_bus_responder_8227.sv
// Directed plus random bench for bus_responder_8227; a transaction-level model of the
// memory map, timer expiry schedule and NMI window predicts every output each cycle.
module tb_bus_responder_8227;

  localparam int         P_PAGES   = 3;
  localparam int         RAM_BYTES = P_PAGES * 256;
  localparam int         P_NMI     = 2;
  localparam logic [7:0] P_OPEN    = 8'hFF;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  addressBusHigh, addressBusLow, cpuWriteData, cpuReadData, hostLoadData;
  logic        readNotWrite, interruptRequest, nonMaskableInterrupt, hostLoadEnable, busError;
  logic [15:0] hostLoadAddr;

  bus_responder_8227 #(.RAM_PAGES(P_PAGES)) dut (
    .clk(clk), .nrst(nrst),
    .addressBusHigh(addressBusHigh), .addressBusLow(addressBusLow),
    .readNotWrite(readNotWrite), .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData),
    .interruptRequest(interruptRequest), .nonMaskableInterrupt(nonMaskableInterrupt),
    .hostLoadEnable(hostLoadEnable), .hostLoadAddr(hostLoadAddr), .hostLoadData(hostLoadData),
    .busError(busError)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: byte store for RAM and vectors, timer as a fire schedule.
  logic [7:0]  mem [int];
  bit          m_en, m_auto, m_pend;
  logic [15:0] m_reload;
  int          cyc = 0;
  int          m_next_fire;
  int          nmi_end;
  logic [7:0]  e_rd;
  bit          e_berr;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int period();
    return (m_reload == 16'd0) ? 1 : int'(m_reload);
  endfunction

  function automatic void model_reset();
    m_en = 0; m_auto = 0; m_pend = 0; m_reload = 16'd0;
    m_next_fire = 0; nmi_end = cyc; e_rd = 8'h00; e_berr = 0;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h03;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h04;
  endfunction

  function automatic void model_edge();
    logic [15:0] a, ha;
    logic [7:0]  wd, rd;
    bit          w, fire, mapped;
    a = {addressBusHigh, addressBusLow};
    ha = hostLoadAddr;
    w = !readNotWrite;
    wd = cpuWriteData;
    cyc++;
    mapped = 1;
    rd = P_OPEN;
    if (int'(a) < RAM_BYTES)   rd = mem[int'(a)];
    else if (a == 16'hD000)    rd = {6'd0, m_auto, m_en};
    else if (a == 16'hD001)    rd = m_reload[7:0];
    else if (a == 16'hD002)    rd = m_reload[15:8];
    else if (a == 16'hD003)    rd = {7'd0, m_pend};
    else if (a == 16'hD004)    rd = 8'h00;
    else if (a >= 16'hFFFA)    rd = mem[int'(a)];
    else                       mapped = 0;
    e_rd = w ? wd : rd;
    e_berr = !mapped;

    fire = m_en && (cyc == m_next_fire);
    if (w && a == 16'hD003 && wd[0]) m_pend = 0;
    if (fire) begin
      m_pend = 1;
      if (m_auto) m_next_fire = cyc + period();
      else m_en = 0;
    end
    if (w && a == 16'hD000) begin
      m_en = wd[0];
      m_auto = wd[1];
      if (wd[0]) m_next_fire = cyc + period();
    end
    if (w && a == 16'hD001) m_reload[7:0] = wd;
    if (w && a == 16'hD002) m_reload[15:8] = wd;
    if (w && a == 16'hD004) nmi_end = cyc + P_NMI;

    if (w && int'(a) < RAM_BYTES && !(hostLoadEnable && ha == a)) mem[int'(a)] = wd;
    if (hostLoadEnable && (int'(ha) < RAM_BYTES || ha >= 16'hFFFA)) mem[int'(ha)] = hostLoadData;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("rdata", cpuReadData, e_rd);
    chk("berr", {7'd0, busError}, {7'd0, e_berr});
    chk("irq", {7'd0, interruptRequest}, {7'd0, m_pend});
    chk("nmi", {7'd0, nonMaskableInterrupt}, {7'd0, (cyc < nmi_end)});
  endtask

  task automatic drive(logic [15:0] a, bit rnw, logic [7:0] d);
    addressBusHigh = a[15:8];
    addressBusLow  = a[7:0];
    readNotWrite   = rnw;
    cpuWriteData   = d;
    hostLoadEnable = 1'b0;
  endtask

  task automatic cpu_rd(logic [15:0] a);
    drive(a, 1'b1, 8'h00);
    tick();
  endtask

  task automatic cpu_wr(logic [15:0] a, logic [7:0] d);
    drive(a, 1'b0, d);
    tick();
  endtask

  task automatic idle();
    cpu_rd(16'hD004);
  endtask

  task automatic host_wr(logic [15:0] ha, logic [7:0] hd);
    drive(16'hD004, 1'b1, 8'h00);
    hostLoadEnable = 1'b1;
    hostLoadAddr   = ha;
    hostLoadData   = hd;
    tick();
  endtask

  initial begin
    logic [15:0] a, ha;
    logic [7:0]  d;
    nrst = 1'b0;
    drive(16'hD004, 1'b1, 8'h00);
    hostLoadAddr = 16'h0000;
    hostLoadData = 8'h00;
    model_reset();
    #12;
    chk("reset_rdata", cpuReadData, 8'h00);
    chk("reset_irq", {7'd0, interruptRequest}, 8'h00);
    chk("reset_nmi", {7'd0, nonMaskableInterrupt}, 8'h00);
    chk("reset_berr", {7'd0, busError}, 8'h00);
    #8 nrst = 1'b1;

    // Reset vector bytes, one cycle after the address.
    cpu_rd(16'hFFFC); chk("vec_fffc", cpuReadData, 8'h00);
    cpu_rd(16'hFFFD); chk("vec_fffd", cpuReadData, 8'h02);

    for (int i = 0; i < RAM_BYTES; i++) host_wr(16'(i), 8'($urandom_range(0, 255)));

    host_wr(16'h0200, 8'h5D);
    cpu_rd(16'h0200);       chk("host_load", cpuReadData, 8'h5D);
    cpu_wr(16'h0042, 8'hF0); chk("wr_echo", cpuReadData, 8'hF0);
    cpu_rd(16'h0042);       chk("ram_rw", cpuReadData, 8'hF0);
    drive(16'h0010, 1'b0, 8'h22);
    hostLoadEnable = 1'b1; hostLoadAddr = 16'h0010; hostLoadData = 8'h11;
    tick();
    cpu_rd(16'h0010);       chk("host_wins", cpuReadData, 8'h11);

    // One-shot timer, RELOAD = 3.
    cpu_wr(16'hD001, 8'h03);
    cpu_wr(16'hD002, 8'h00);
    cpu_wr(16'hD000, 8'h01); chk("irq_e0", {7'd0, interruptRequest}, 8'h00);
    idle();
    idle();                  chk("irq_e2", {7'd0, interruptRequest}, 8'h00);
    idle();                  chk("irq_e3", {7'd0, interruptRequest}, 8'h01);
    cpu_rd(16'hD000);        chk("ctrl_autoclr", cpuReadData, 8'h00);
    cpu_rd(16'hD003);        chk("status", cpuReadData, 8'h01);
    cpu_wr(16'hD003, 8'h01); chk("irq_clear", {7'd0, interruptRequest}, 8'h00);

    // Auto-reload, RELOAD = 2: expiries on E2, E4, E6 ...
    cpu_wr(16'hD001, 8'h02);
    cpu_wr(16'hD000, 8'h03);
    idle();                  chk("auto_e1", {7'd0, interruptRequest}, 8'h00);
    idle();                  chk("auto_e2", {7'd0, interruptRequest}, 8'h01);
    cpu_wr(16'hD003, 8'h01); chk("auto_clr_e3", {7'd0, interruptRequest}, 8'h00);
    idle();                  chk("auto_e4", {7'd0, interruptRequest}, 8'h01);
    idle();
    cpu_wr(16'hD003, 8'h01); chk("set_wins_e6", {7'd0, interruptRequest}, 8'h01);
    cpu_wr(16'hD003, 8'h01); chk("auto_clr_e7", {7'd0, interruptRequest}, 8'h00);
    cpu_wr(16'hD000, 8'h00);
    cpu_wr(16'hD003, 8'h01);
    idle();
    idle();                  chk("timer_off", {7'd0, interruptRequest}, 8'h00);

    // NMI pulse, then a retrigger sampled on the pulse's second edge.
    cpu_wr(16'hD004, 8'h5A); chk("nmi_c1", {7'd0, nonMaskableInterrupt}, 8'h01);
    idle();                  chk("nmi_c2", {7'd0, nonMaskableInterrupt}, 8'h01);
    idle();                  chk("nmi_end", {7'd0, nonMaskableInterrupt}, 8'h00);
    cpu_wr(16'hD004, 8'h00);
    cpu_wr(16'hD004, 8'h00); chk("nmi_rt2", {7'd0, nonMaskableInterrupt}, 8'h01);
    idle();                  chk("nmi_rt3", {7'd0, nonMaskableInterrupt}, 8'h01);
    idle();                  chk("nmi_rt_end", {7'd0, nonMaskableInterrupt}, 8'h00);

    cpu_rd(16'h8000);
    chk("open_bus", cpuReadData, 8'hFF);
    chk("berr_pulse", {7'd0, busError}, 8'h01);
    idle();                  chk("berr_drop", {7'd0, busError}, 8'h00);
    cpu_wr(16'hFFFC, 8'h77);
    cpu_rd(16'hFFFC);        chk("vec_ro", cpuReadData, 8'h00);

    // Random traffic over every region.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom_range(0, RAM_BYTES - 1));
        1:       a = 16'hD000 + 16'($urandom_range(0, 4));
        2:       a = 16'hFFFA + 16'($urandom_range(0, 5));
        3:       a = 16'($urandom_range(16'h0400, 16'hCFFF));
        default: a = 16'($urandom_range(0, 16'hFFFF));
      endcase
      d = 8'($urandom_range(0, 255));
      if (a == 16'hD001) d = 8'($urandom_range(0, 6));
      if (a == 16'hD002) d = 8'h00;
      drive(a, 1'($urandom_range(0, 1)), d);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       ha = a;
          1:       ha = 16'hFFFA + 16'($urandom_range(0, 5));
          default: ha = 16'($urandom_range(0, RAM_BYTES - 1));
        endcase
        hostLoadEnable = 1'b1;
        hostLoadAddr   = ha;
        hostLoadData   = 8'($urandom_range(0, 255));
      end
      tick();
    end

    // Asynchronous reset in the middle of a countdown.
    cpu_wr(16'hD000, 8'h00);
    host_wr(16'hFFFC, 8'hAB);
    cpu_rd(16'hFFFC);        chk("vec_host", cpuReadData, 8'hAB);
    cpu_wr(16'hD001, 8'h20);
    cpu_wr(16'hD002, 8'h00);
    cpu_wr(16'hD000, 8'h01);
    cpu_wr(16'hD004, 8'h01);
    cpu_rd(16'h8000);
    chk("pre_rst_berr", {7'd0, busError}, 8'h01);
    chk("pre_rst_nmi", {7'd0, nonMaskableInterrupt}, 8'h01);
    #2 nrst = 1'b0;
    model_reset();
    #1;
    chk("arst_rdata", cpuReadData, 8'h00);
    chk("arst_irq", {7'd0, interruptRequest}, 8'h00);
    chk("arst_nmi", {7'd0, nonMaskableInterrupt}, 8'h00);
    chk("arst_berr", {7'd0, busError}, 8'h00);
    @(negedge clk) nrst = 1'b1;
    cpu_rd(16'hFFFC);        chk("vec_restored", cpuReadData, 8'h00);
    cpu_rd(16'hD000);        chk("ctrl_reset", cpuReadData, 8'h00);
    for (int i = 0; i < 40; i++) idle();
    chk("timer_reset", {7'd0, interruptRequest}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
